// File: rtl/pe_weight_loader.sv
// Weight loader for a weight-stationary systolic array: buffers ROWS weight rows,
// then replays them last-row-first down the column chains under a ROWS-cycle wen window.
module pe_weight_loader #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COLS*8-1:0]   in_data,
  output logic                wen,
  output logic [COLS*8-1:0]   w_out,
  output logic                busy,
  output logic                done
);

  localparam int W  = COLS * 8;
  localparam int CW = $clog2(ROWS + 1);
  localparam int AW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   row_cnt_reg;
  logic [CW-1:0]   shift_cnt_reg;
  logic [W-1:0]    row_mem [ROWS];
  logic            fill_wr;
  logic [ROWS-1:0] row_wr;
  logic [AW-1:0]   rd_idx;

  assign fill_wr = (state_reg == FILL) && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_wr
      assign row_wr[gi] = fill_wr && (row_cnt_reg == CW'(gi));
    end
  endgenerate

  // Outputs are registered one cycle ahead, so fetch the row for the next shift step.
  assign rd_idx = LAST_IDX - shift_cnt_reg[AW-1:0] - AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) row_mem[i] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (row_wr[i]) row_mem[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      row_cnt_reg   <= '0;
      shift_cnt_reg <= '0;
      in_ready      <= 1'b0;
      wen           <= 1'b0;
      w_out         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= FILL;
            row_cnt_reg <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FILL: begin
          if (in_valid) begin
            row_cnt_reg <= row_cnt_reg + CW'(1);
            if (row_cnt_reg == LAST_CNT) begin
              // The last row is emitted first; it is still on in_data this cycle.
              state_reg     <= SHIFT;
              shift_cnt_reg <= '0;
              in_ready      <= 1'b0;
              wen           <= 1'b1;
              w_out         <= in_data;
            end
          end
        end
        SHIFT: begin
          if (shift_cnt_reg == LAST_CNT) begin
            state_reg <= DONE;
            wen       <= 1'b0;
            w_out     <= '0;
            done      <= 1'b1;
          end else begin
            shift_cnt_reg <= shift_cnt_reg + CW'(1);
            w_out         <= row_mem[rd_idx];
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  a_wout_gated: assert property (@(posedge clk) disable iff (!reset_n) !wen |-> (w_out == '0));
  a_done_no_wen: assert property (@(posedge clk) disable iff (!reset_n) done |-> !wen);

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: table of directed sequences, hand-written reset and
// back-to-back cases, and random sequences checked against a cycle-position model.
module tb_pe_weight_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = COLS * 8;

  typedef logic [ROWS-1:0][W-1:0] rowset_t;

  typedef struct {
    string          name;
    rowset_t        rows;
    int             stall_at;
    int             n_stall;
    bit             junk;
    bit             spam;
    int             exp_done_rel;
    logic [W-1:0]   exp_pe0;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         wen;
  logic [W-1:0] w_out;
  logic         busy;
  logic         done;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] pe [ROWS];

  pe_weight_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wen      (wen),
    .w_out    (w_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Downstream PE column model: each PE captures its input when wen is high.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      for (int r = ROWS - 1; r > 0; r--) pe[r] = pe[r-1];
      pe[0] = w_out;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one full sequence starting at the next negedge and checks every cycle
  // against the expected timeline derived from ROWS and the number of stall cycles.
  task automatic run_seq(input string tag, input rowset_t rows, input int stall_at,
                         input int n_stall, input bit junk, input bit spam,
                         output int done_cnt, output int done_rel);
    int fill_len;
    int last;
    int f;
    int idx;
    bit e_ready, e_wen, e_done, e_busy;
    logic [W-1:0] e_w;
    fill_len = ROWS + n_stall;
    last     = 2 * ROWS + n_stall + 1;
    done_cnt = 0;
    done_rel = -1;
    @(negedge clk);
    chk($sformatf("%s c0 ready", tag), W'(in_ready), '0);
    chk($sformatf("%s c0 wen", tag), W'(wen), '0);
    chk($sformatf("%s c0 busy", tag), W'(busy), '0);
    chk($sformatf("%s c0 done", tag), W'(done), '0);
    start    = 1'b1;
    in_valid = junk;
    in_data  = $urandom;
    for (int rel = 1; rel <= last; rel++) begin
      @(negedge clk);
      e_ready = (rel <= fill_len);
      e_wen   = (rel > fill_len) && (rel <= fill_len + ROWS);
      idx     = ROWS - (rel - fill_len);
      e_w     = e_wen ? rows[idx] : '0;
      e_done  = (rel == last);
      e_busy  = (rel <= last);
      chk($sformatf("%s c%0d in_ready", tag, rel), W'(in_ready), W'(e_ready));
      chk($sformatf("%s c%0d wen", tag, rel), W'(wen), W'(e_wen));
      chk($sformatf("%s c%0d w_out", tag, rel), w_out, e_w);
      chk($sformatf("%s c%0d busy", tag, rel), W'(busy), W'(e_busy));
      chk($sformatf("%s c%0d done", tag, rel), W'(done), W'(e_done));
      if (done === 1'b1) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      start = spam && (rel == 2 || rel == fill_len + 2);
      if (e_ready) begin
        f = rel - 1;
        if (f >= stall_at && f < stall_at + n_stall) begin
          in_valid = 1'b0;
          in_data  = $urandom;
        end else begin
          in_valid = 1'b1;
          in_data  = rows[(f < stall_at) ? f : f - n_stall];
        end
      end else begin
        in_valid = junk;
        in_data  = $urandom;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("%s pe_row%0d", tag, r), pe[r], rows[r]);
  endtask

  vec_t    tbl [4];
  rowset_t ra, rb;
  int      dcnt, drel;
  logic signed [7:0] lane;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    for (int r = 0; r < ROWS; r++) pe[r] = '0;

    tbl[0].name = "basic";
    tbl[0].rows[0] = 32'h01010101; tbl[0].rows[1] = 32'h02020202;
    tbl[0].rows[2] = 32'h03030303; tbl[0].rows[3] = 32'h04040404;
    tbl[0].stall_at = 0; tbl[0].n_stall = 0; tbl[0].junk = 0; tbl[0].spam = 0;
    tbl[0].exp_done_rel = 9; tbl[0].exp_pe0 = 32'h01010101;

    tbl[1].name = "signed";
    tbl[1].rows = '0; tbl[1].rows[0] = 32'h80FF7F01;
    tbl[1].stall_at = 0; tbl[1].n_stall = 0; tbl[1].junk = 0; tbl[1].spam = 0;
    tbl[1].exp_done_rel = 9; tbl[1].exp_pe0 = 32'h80FF7F01;

    tbl[2].name = "stall";
    tbl[2].rows = tbl[0].rows;
    tbl[2].stall_at = 2; tbl[2].n_stall = 3; tbl[2].junk = 0; tbl[2].spam = 0;
    tbl[2].exp_done_rel = 12; tbl[2].exp_pe0 = 32'h01010101;

    tbl[3].name = "spurious";
    tbl[3].rows[0] = 32'hA1B2C3D4; tbl[3].rows[1] = 32'h11223344;
    tbl[3].rows[2] = 32'h5566778F; tbl[3].rows[3] = 32'hFEDCBA98;
    tbl[3].stall_at = 1; tbl[3].n_stall = 1; tbl[3].junk = 1; tbl[3].spam = 1;
    tbl[3].exp_done_rel = 10; tbl[3].exp_pe0 = 32'hA1B2C3D4;

    repeat (3) @(negedge clk);
    chk("reset in_ready", W'(in_ready), '0);
    chk("reset wen", W'(wen), '0);
    chk("reset w_out", w_out, '0);
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      run_seq(tbl[t].name, tbl[t].rows, tbl[t].stall_at, tbl[t].n_stall,
              tbl[t].junk, tbl[t].spam, dcnt, drel);
      chk_s({tbl[t].name, " done_count"}, dcnt, 1);
      chk_s({tbl[t].name, " done_cycle"}, drel, tbl[t].exp_done_rel);
      chk({tbl[t].name, " pe0"}, pe[0], tbl[t].exp_pe0);
      $display("vector %s: done at cycle %0d, pe0=%h", tbl[t].name, drel, pe[0]);
      if (t == 1) begin
        lane = pe[0][31:24]; chk_s("signed lane3", int'(lane), -128);
        lane = pe[0][23:16]; chk_s("signed lane2", int'(lane), -1);
        lane = pe[0][15:8];  chk_s("signed lane1", int'(lane), 127);
        lane = pe[0][7:0];   chk_s("signed lane0", int'(lane), 1);
      end
      @(negedge clk);
    end

    // Reset during SHIFT at s=1.
    ra[0] = 32'h0A0B0C0D; ra[1] = 32'h1A1B1C1D; ra[2] = 32'h2A2B2C2D; ra[3] = 32'h3A3B3C3D;
    @(negedge clk);
    start = 1'b1;
    for (int f = 0; f < ROWS; f++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = ra[f];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset shift s0 wen", W'(wen), W'(1'b1));
    @(negedge clk);
    chk("pre-reset shift s1 w_out", w_out, ra[2]);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset wen", W'(wen), '0);
    chk("midreset w_out", w_out, '0);
    chk("midreset busy", W'(busy), '0);
    chk("midreset done", W'(done), '0);
    chk("midreset in_ready", W'(in_ready), '0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("postreset c%0d wen", c), W'(wen), '0);
      chk($sformatf("postreset c%0d busy", c), W'(busy), '0);
    end
    $display("reset mid-shift: outputs cleared, loader idle");
    rb[0] = 32'h7F00807F; rb[1] = 32'h00FF00FF; rb[2] = 32'h12345678; rb[3] = 32'h9ABCDEF0;
    run_seq("after_reset", rb, 0, 0, 0, 0, dcnt, drel);
    chk_s("after_reset done_count", dcnt, 1);

    // Back-to-back sequences with start in the first idle cycle after done.
    run_seq("b2b_a", ra, 0, 0, 0, 0, dcnt, drel);
    chk_s("b2b_a done_count", dcnt, 1);
    run_seq("b2b_b", rb, 3, 2, 1, 0, dcnt, drel);
    chk_s("b2b_b done_count", dcnt, 1);
    chk_s("b2b_b done_cycle", drel, 2 * ROWS + 2 + 1);
    $display("back-to-back: second load pe0=%h", pe[0]);

    for (int it = 0; it < 6; it++) begin
      rowset_t rr;
      int sa, ns;
      for (int r = 0; r < ROWS; r++) rr[r] = $urandom;
      sa = $urandom_range(0, ROWS - 1);
      ns = $urandom_range(0, 3);
      run_seq($sformatf("rand%0d", it), rr, sa, ns, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), dcnt, drel);
      chk_s($sformatf("rand%0d done_count", it), dcnt, 1);
      chk_s($sformatf("rand%0d done_cycle", it), drel, 2 * ROWS + ns + 1);
      $display("random seq %0d: stall_at=%0d n_stall=%0d done at cycle %0d", it, sa, ns, drel);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
